// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS-subset datapath: sequences shared
// PC/IR/ALU/memory/register-file resources one state per enabled step.
module multi_cycle_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step_en,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic             pc_write,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [4:0]       type_led,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LW_WB    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BEQ      = 4'd8,
    S_JMP      = 4'd9
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             illegal_q, illegal_d;
  logic [4:0]       type_led_q, type_led_d;
  logic             done_q, done_d;

  logic [4:0] type_dec;
  logic       op_legal;
  logic       final_st;
  logic       pcw_uncond, pcw_cond, irw_m, memw_m, regw_m;

  // Opcode class as {R,LW,SW,BEQ,J}; all-zero marks an unknown opcode.
  always_comb begin
    type_dec = 5'b00000;
    case (opcode)
      OP_RTYPE: type_dec = 5'b10000;
      OP_LW:    type_dec = 5'b01000;
      OP_SW:    type_dec = 5'b00100;
      OP_BEQ:   type_dec = 5'b00010;
      OP_J:     type_dec = 5'b00001;
      default:  type_dec = 5'b00000;
    endcase
  end

  assign op_legal = |type_dec;
  assign final_st = (state_q == S_LW_WB) || (state_q == S_MEM_WR) ||
                    (state_q == S_R_WB)  || (state_q == S_BEQ)    ||
                    (state_q == S_JMP);

  // Next-state: moves only on enabled steps; unreachable codes recover to FETCH.
  always_comb begin
    state_d = state_q;
    if (step_en) begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          if (type_dec[3] || type_dec[2]) state_d = S_MEM_ADDR;
          else if (type_dec[4])           state_d = S_R_EXEC;
          else if (type_dec[1])           state_d = S_BEQ;
          else if (type_dec[0])           state_d = S_JMP;
          else                            state_d = S_FETCH;
        end
        S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   state_d = S_LW_WB;
        S_R_EXEC:   state_d = S_R_WB;
        default:    state_d = S_FETCH;
      endcase
    end
  end

  // Bookkeeping next values: counters, sticky illegal flag, type LEDs, done pulse.
  always_comb begin
    cycles_d   = cycles_q;
    retired_d  = retired_q;
    illegal_d  = illegal_q;
    type_led_d = type_led_q;
    done_d     = step_en && final_st;
    if (step_en) begin
      cycles_d = cycles_q + CNT_W'(1);
      if (final_st) retired_d = retired_q + CNT_W'(1);
      if (state_q == S_DECODE) begin
        type_led_d = type_dec;
        if (!op_legal) illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      retired_q  <= '0;
      cycles_q   <= '0;
      illegal_q  <= 1'b0;
      type_led_q <= 5'b00000;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      retired_q  <= retired_d;
      cycles_q   <= cycles_d;
      illegal_q  <= illegal_d;
      type_led_q <= type_led_d;
      done_q     <= done_d;
    end
  end

  // Moore decode of datapath controls from the registered state.
  always_comb begin
    pcw_uncond = 1'b0;
    pcw_cond   = 1'b0;
    irw_m      = 1'b0;
    memw_m     = 1'b0;
    regw_m     = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    case (state_q)
      S_FETCH: begin
        irw_m      = 1'b1;
        pcw_uncond = 1'b1;
        alu_src_b  = 2'b01;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD:   iord = 1'b1;
      S_LW_WB: begin
        mem_to_reg = 1'b1;
        regw_m     = 1'b1;
      end
      S_MEM_WR: begin
        iord   = 1'b1;
        memw_m = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_dst = 1'b1;
        regw_m  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        pcw_cond  = 1'b1;
      end
      S_JMP: begin
        pc_source  = 2'b10;
        pcw_uncond = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobes fire once per step and never while reset is held.
  assign pc_write  = step_en && !reset && (pcw_uncond || (pcw_cond && zero));
  assign ir_write  = step_en && !reset && irw_m;
  assign mem_write = step_en && !reset && memw_m;
  assign reg_write = step_en && !reset && regw_m;

  assign state      = state_q;
  assign instr_done = done_q;
  assign illegal    = illegal_q;
  assign type_led   = type_led_q;
  assign retired    = retired_q;
  assign cycles     = cycles_q;

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS-subset datapath (next lab after the single-cycle CPU).
- Sequences shared PC/IR/ALU/memory/register-file resources over 3–5 steps per instruction.
- Advances one state per `step_en` (debounced single-step or free-run enable).
- Exposes state and retire counters for the 7-seg debug display and LEDs.

Parameters:
- CNT_W, 16, width of instruction-retire and cycle counters.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, reset.
- step_en, input, 1, advance enable; FSM and counters move only on clock edges with step_en=1.
- opcode, input, 6, IR[31:26] (valid from DECODE onward).
- zero, input, 1, ALU zero flag.
- pc_write, output, 1, PC load strobe (unconditional | cond&zero), gated by step_en.
- iord, output, 1, memory address select: 0=PC, 1=ALUOut.
- mem_write, output, 1, memory write strobe, gated.
- ir_write, output, 1, IR load strobe, gated.
- reg_dst, output, 1, 0=rt, 1=rd.
- mem_to_reg, output, 1, 0=ALUOut, 1=MDR.
- reg_write, output, 1, register-file write strobe, gated.
- alu_src_a, output, 1, 0=PC, 1=A.
- alu_src_b, output, 2, 00=B, 01=4, 10=signext, 11=signext<<2.
- alu_op, output, 2, 00=add, 01=sub, 10=funct.
- pc_source, output, 2, 00=ALU result, 01=ALUOut, 10=jump target.
- state, output, 4, current state code.
- instr_done, output, 1, one-cycle pulse on the edge that leaves a final state.
- illegal, output, 1, sticky: unknown opcode seen.
- type_led, output, 5, {R,LW,SW,BEQ,J}, one-hot of the decoded instruction, held until next DECODE.
- retired, output, CNT_W, instructions completed.
- cycles, output, CNT_W, steps taken.

Behaviour:
- Reset is asynchronous and active-high; clock is `clock`. Reset may occur at any time, mid-instruction included. On reset:
  - state=FETCH(0); retired=0; cycles=0; illegal=0; type_led=0; instr_done=0.
  - Gated strobes are 0 while reset is high.
- State codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, LW_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BEQ=8, JMP=9. Codes 10–15 are unreachable and go to FETCH on the next step.
- Transitions are taken only on a clock edge with step_en=1; otherwise state holds.
  - FETCH -> DECODE.
  - DECODE -> by opcode:
    - 100011 or 101011 -> MEM_ADDR
    - 000000 -> R_EXEC
    - 000100 -> BEQ
    - 000010 -> JMP
    - other -> FETCH, sets illegal, no type_led bit set.
  - MEM_ADDR -> MEM_RD (LW) or MEM_WR (SW); opcode is re-sampled here.
  - MEM_RD -> LW_WB.
  - R_EXEC -> R_WB.
  - LW_WB, MEM_WR, R_WB, BEQ, JMP -> FETCH.
- Outputs are Moore (decoded from registered state). Unlisted outputs are 0 in every state.
  - FETCH: iord=0, ir_write, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, unconditional PC write.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEM_RD: iord=1.
  - LW_WB: reg_dst=0, mem_to_reg=1, reg_write.
  - MEM_WR: iord=1, mem_write.
  - R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
  - R_WB: reg_dst=1, mem_to_reg=0, reg_write.
  - BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, conditional PC write; pc_write=step_en&zero.
  - JMP: pc_source=10, unconditional PC write.
- Strobe gating: pc_write, ir_write, mem_write and reg_write are each the state's Moore value AND step_en. A stall with step_en=0 therefore never produces a repeated write. Mux selects are not gated.
- Counters:
  - cycles increments on every step_en edge.
  - retired increments on every edge leaving LW_WB, MEM_WR, R_WB, BEQ or JMP. Illegal opcodes do not count.
  - Both wrap at 2^CNT_W−1 -> 0 without flagging.
- instr_done is registered: high for exactly one clock after a retiring step.
- type_led is loaded on the DECODE step edge.
- Cycles per instruction: LW=5, SW=4, R=4, BEQ=3, J=3.

Test Plan:
- Reset pulse mid-MEM_RD, then release -> state=0, retired=0, cycles=0, all strobes 0 with step_en=0.
- LW (opcode 100011), step_en=1 for 5 clocks -> states 0,1,2,3,4,0; reg_write=1 only in LW_WB with mem_to_reg=1; retired=1; type_led=01000; instr_done single pulse.
- BEQ with zero=1, then BEQ with zero=0 -> pc_write=1 in state 8 only for zero=1; each takes 3 steps; retired=2.
- R-type with step_en toggling 1,0,0,1,... -> state holds during 0s; ir_write/reg_write never high while step_en=0; cycles counts only enabled edges.
- Opcode 111111 -> DECODE->FETCH, illegal=1 (stays set after next valid J), retired unchanged; J then retires in 3 steps with pc_source=10.
- CNT_W=4: run 16 J instructions -> retired wraps 15->0.
